// File: rtl/team_06_pkg.sv
// rtl/team_06_pkg.sv - shared types and constants for the delay-line SRAM controller
package team_06_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DEPTH  = 4096;
  localparam logic [7:0] SILENCE = 8'd128;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } state_t;

endpackage

// File: rtl/team_06_delay_sram_ctrl.sv
// rtl/team_06_delay_sram_ctrl.sv - audio delay line: writes each recorded sample to
// an external SRAM ring and optionally reads back the sample delay_len steps older
module team_06_delay_sram_ctrl
  import team_06_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              record,
  input  logic              search,
  input  logic [7:0]        save_audio,
  input  logic [ADDR_W-1:0] delay_len,
  output logic [7:0]        past_output,
  output logic              goodData,
  output logic              busy,
  output logic              overrun,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   fill;
  logic              pend;
  logic [7:0]        pend_data;

  logic              ack_wr;
  logic              accept;
  logic              drop;
  logic              pend_n;
  logic [7:0]        pdata_n;
  logic [ADDR_W-1:0] wr_ptr_inc;
  logic [ADDR_W-1:0] eff_delay;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   fill_inc;
  logic              primed;

  always_comb begin
    ack_wr  = (state == WRITE) && mem_ack;
    // The write completing this cycle frees the pending slot for a new record.
    accept  = record && (!pend || ack_wr);
    drop    = record && pend && !ack_wr;
    pend_n  = accept || (pend && !ack_wr);
    pdata_n = accept ? save_audio : pend_data;

    wr_ptr_inc = (wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr + ADDR_W'(1);
    fill_inc   = (fill == (ADDR_W+1)'(DEPTH)) ? fill : fill + (ADDR_W+1)'(1);

    if (delay_len == '0)
      eff_delay = ADDR_W'(1);
    else if ({1'b0, delay_len} > (ADDR_W+1)'(DEPTH - 1))
      eff_delay = ADDR_W'(DEPTH - 1);
    else
      eff_delay = delay_len;

    // Read issued right after the write, so (wr_ptr+1) - 1 - delay == wr_ptr - delay.
    rd_addr = wr_ptr + ADDR_W'(DEPTH) - eff_delay;
    primed  = fill > {1'b0, eff_delay};
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      fill        <= '0;
      pend        <= 1'b0;
      pend_data   <= 8'd0;
      overrun     <= 1'b0;
      past_output <= SILENCE;
      goodData    <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 8'd0;
    end else begin
      pend      <= pend_n;
      pend_data <= pdata_n;
      if (drop)
        overrun <= 1'b1;
      if (record || !search)
        goodData <= 1'b0;

      case (state)
        IDLE: begin
          if (pend) begin
            state     <= WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= wr_ptr;
            mem_wdata <= pend_data;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            wr_ptr <= wr_ptr_inc;
            fill   <= fill_inc;
            if (search) begin
              state    <= READ;
              mem_we   <= 1'b0;
              mem_addr <= rd_addr;
            end else if (pend_n) begin
              mem_addr  <= wr_ptr_inc;
              mem_wdata <= pdata_n;
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
            end
          end
        end
        READ: begin
          if (mem_ack) begin
            past_output <= primed ? mem_rdata : SILENCE;
            goodData    <= primed && search;
            if (pend_n) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_addr  <= wr_ptr;
              mem_wdata <= pdata_n;
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_team_06_delay_sram_ctrl.sv
// tb/tb_team_06_delay_sram_ctrl.sv - directed bench for team_06_delay_sram_ctrl
module tb_team_06_delay_sram_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       record = 1'b0;
  logic       search = 1'b0;
  logic [7:0] save_audio = 8'd0;
  logic [3:0] delay_len = 4'd0;
  logic [7:0] past_output;
  logic       goodData;
  logic       busy;
  logic       overrun;
  logic       mem_req;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'd0;
  logic       mem_ack;

  logic       model_ack = 1'b0;
  logic       stray_ack = 1'b0;
  logic       mem_en = 1'b1;
  int         lat = 0;
  int         cnt = 0;
  int         wr_count = 0;
  int         rd_count = 0;
  int         last_rd = -1;
  logic [7:0] mem [16];

  int vec = 0;
  int errs = 0;

  assign mem_ack = model_ack | stray_ack;

  team_06_delay_sram_ctrl #(.ADDR_W(4), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .record(record), .search(search),
    .save_audio(save_audio), .delay_len(delay_len),
    .past_output(past_output), .goodData(goodData), .busy(busy),
    .overrun(overrun), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // SRAM model: acks a held request after lat extra cycles, one-cycle strobe.
  always @(negedge clk) begin
    if (!rst || !mem_en) begin
      model_ack = 1'b0;
      cnt = 0;
    end else if (model_ack) begin
      model_ack = 1'b0;
    end else if (mem_req) begin
      if (cnt >= lat) begin
        model_ack = 1'b1;
        cnt = 0;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          wr_count++;
        end else begin
          mem_rdata = mem[mem_addr];
          last_rd = int'(mem_addr);
          rd_count++;
        end
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic rec(input logic [7:0] v);
    record = 1'b1;
    save_audio = v;
    @(negedge clk);
    record = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] s [20];
    int wbase;
    int rbase;
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_past", past_output, 128);
    chk("rst_good", goodData, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst = 1'b1;
    @(negedge clk);

    // Delay 3, zero-wait memory: first three reads are silence
    search = 1'b1;
    delay_len = 4'd3;
    rec(8'd10);
    chk("lat_req_early", mem_req, 0);
    @(negedge clk);
    chk("lat_req", mem_req, 1);
    chk("lat_we", mem_we, 1);
    chk("lat_addr", mem_addr, 0);
    chk("lat_wdata", mem_wdata, 10);
    wait_idle();
    chk("d3_10_past", past_output, 128);
    chk("d3_10_good", goodData, 0);
    rec(8'd20); wait_idle();
    chk("d3_20_past", past_output, 128);
    rec(8'd30); wait_idle();
    chk("d3_30_past", past_output, 128);
    chk("d3_30_good", goodData, 0);
    rec(8'd40); wait_idle();
    chk("d3_40_past", past_output, 10);
    chk("d3_40_good", goodData, 1);
    rec(8'd50);
    chk("good_fall_on_record", goodData, 0);
    wait_idle();
    chk("d3_50_past", past_output, 20);
    chk("d3_50_good", goodData, 1);
    rec(8'd60); wait_idle();
    chk("d3_60_past", past_output, 30);

    // delay_len 0 acts as delay 1; change applies without a flush
    delay_len = 4'd0;
    rec(8'd5); wait_idle();
    chk("d0_5_past", past_output, 60);
    rec(8'd6); wait_idle();
    chk("d0_6_past", past_output, 5);
    rec(8'd7); wait_idle();
    chk("d0_7_past", past_output, 6);
    chk("d0_7_good", goodData, 1);

    // search low: writes only
    do_reset();
    search = 1'b0;
    wbase = wr_count;
    rbase = rd_count;
    for (int i = 0; i < 4; i++) begin
      s[i] = 8'(i + 1);
      rec(s[i]); wait_idle();
      chk("ns_past", past_output, 128);
      chk("ns_good", goodData, 0);
    end
    chk("ns_writes", wr_count - wbase, 4);
    chk("ns_reads", rd_count - rbase, 0);

    // Pointer wrap 15->0 over 20 total writes, delay 3
    search = 1'b1;
    delay_len = 4'd3;
    for (int k = 4; k < 20; k++) begin
      s[k] = 8'(100 + k - 4);
      rec(s[k]); wait_idle();
      chk("wrap_wmem", mem[k % 16], s[k]);
      chk("wrap_raddr", last_rd, (k - 3) % 16);
      chk("wrap_past", past_output, s[k - 3]);
      chk("wrap_good", goodData, 1);
    end

    // Record on the cycle the write acks is accepted, not an overrun
    do_reset();
    search = 1'b0;
    lat = 0;
    rec(8'd55);
    @(negedge clk);
    rec(8'd66);
    chk("coinc_ovr", overrun, 0);
    chk("coinc_req", mem_req, 1);
    chk("coinc_addr", mem_addr, 1);
    chk("coinc_wdata", mem_wdata, 66);
    wait_idle();
    chk("coinc_mem0", mem[0], 55);
    chk("coinc_mem1", mem[1], 66);

    // Slow memory: records during an outstanding write are dropped
    lat = 5;
    wbase = wr_count;
    rec(8'd11);
    @(negedge clk);
    rec(8'd22);
    chk("ovr_set", overrun, 1);
    @(negedge clk);
    rec(8'd33);
    wait_idle();
    chk("ovr_writes1", wr_count - wbase, 1);
    rec(8'd44); wait_idle();
    chk("ovr_writes2", wr_count - wbase, 2);
    chk("ovr_mem2", mem[2], 11);
    chk("ovr_mem3", mem[3], 44);
    chk("ovr_sticky", overrun, 1);

    // Reset in the middle of a read, then a stray ack
    do_reset();
    chk("ovr_cleared", overrun, 0);
    lat = 3;
    search = 1'b1;
    delay_len = 4'd3;
    rec(8'd9);
    n = 0;
    while (!(mem_req && !mem_we) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("r25_in_read", mem_req && !mem_we, 1);
    rst = 1'b0;
    #1;
    chk("r25_req", mem_req, 0);
    chk("r25_busy", busy, 0);
    chk("r25_addr", mem_addr, 0);
    chk("r25_past", past_output, 128);
    chk("r25_good", goodData, 0);
    @(negedge clk);
    rst = 1'b1;
    mem_en = 1'b0;
    wbase = wr_count;
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    chk("stray_busy", busy, 0);
    chk("stray_req", mem_req, 0);
    chk("stray_writes", wr_count - wbase, 0);
    mem_en = 1'b1;
    lat = 0;
    rec(8'd77);
    @(negedge clk);
    chk("post_rst_addr", mem_addr, 0);
    chk("post_rst_wdata", mem_wdata, 77);
    wait_idle();
    chk("post_rst_mem", mem[0], 77);
    chk("post_rst_past", past_output, 128);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/team_06_delay_sram_ctrl.md
TEAM_06_DELAY_SRAM_CTRL -- requirements
Module: team_06_delay_sram_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_W, 12, delay-buffer address width; DEPTH, 4096, buffer depth in samples (2**ADDR_W).
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- record  in  1  one-cycle pulse: store save_audio as newest sample
- search  in  1  level: read delayed sample after each stored sample
- save_audio  in  8  unsigned sample to store
- delay_len  in  ADDR_W  delay in samples
- past_output  out  8  delayed sample returned to effect block
- goodData  out  1  past_output valid and buffer primed
- busy  out  1  FSM not in IDLE
- overrun  out  1  sticky: record lost
- mem_req  out  1  memory request
- mem_we  out  1  1 write / 0 read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion strobe

Function
REQ-003 FSM states SHALL be IDLE, WRITE, READ; request held (mem_req=1, mem_addr/mem_we/mem_wdata stable) in WRITE/READ until mem_ack.
REQ-004 record SHALL latch save_audio into a 1-entry pending register and set pend; IDLE with pend set goes to WRITE next cycle.
REQ-005 WRITE SHALL address wr_ptr; on mem_ack wr_ptr increments modulo DEPTH (DEPTH-1 wraps to 0), pend clears, fill count increments saturating at DEPTH.
REQ-006 On WRITE mem_ack: search=1 -> READ; else pend set -> WRITE; else IDLE.
REQ-007 READ address SHALL be (wr_ptr - 1 - eff_delay) mod DEPTH, wr_ptr post-increment; eff_delay = delay_len clamped to 1..DEPTH-1 (0 treated as 1).
REQ-008 READ mem_ack SHALL register mem_rdata into past_output next edge; state -> WRITE if pend set, else IDLE.
REQ-009 Buffer primed when fill count > eff_delay; unprimed READ mem_ack SHALL set past_output to 8'd128 (midscale silence), not mem_rdata.
REQ-010 goodData SHALL rise on the edge past_output updates from a primed read, fall on next record, and stay 0 while search=0.
REQ-011 record while pend already set SHALL drop the new sample, keep the older pending one, and set overrun (sticky until reset).
REQ-012 record in the same cycle a WRITE mem_ack clears pend SHALL be accepted (pend stays set, new data latched), not an overrun.
REQ-013 search falling while in READ SHALL NOT abort the read; result still latched, goodData held 0.
REQ-014 delay_len change SHALL take effect at next READ address computation; no flush.
REQ-015 mem_ack outside WRITE/READ SHALL be ignored.
REQ-016 Latency: IDLE record to mem_req SHALL be 2 cycles (latch, then WRITE).

Reset
REQ-017 rst=0 SHALL asynchronously force: state IDLE, wr_ptr 0, fill 0, pend 0, overrun 0, past_output 8'd128, goodData 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0.
REQ-018 Reset mid-transaction SHALL abandon it; late mem_ack after release is ignored per REQ-015.

Structure
REQ-019 Shared package team_06_pkg SHALL hold state enum, ADDR_W/DEPTH defaults, SILENCE = 8'd128.
REQ-020 No sub-module; single FSM plus pointer/fill counters.

Verification
REQ-021 Zero-wait memory model (ack 1 cycle after req), delay_len=3, search=1, record samples 10,20,30,40,50 -> first three reads 128 / goodData 0; after 40, past_output=10 goodData=1; after 50, 20.
REQ-022 delay_len=0, samples 5,6,7 -> behaves as delay 1: after 7, past_output=6.
REQ-023 DEPTH=16 (ADDR_W=4), 20 writes -> wr_ptr wraps 15->0; read address mod 16 correct; data matches model.
REQ-024 Ack latency 5 cycles, records every 2 cycles -> one sample held pending, next dropped, overrun=1, stored stream skips dropped values.
REQ-025 Drop rst to 0 during READ with mem_req=1 -> outputs immediately at REQ-017 values; stray mem_ack afterwards causes no write/state change.
REQ-026 search=0, records 1..4 -> four writes, no reads, goodData stays 0, past_output stays 128.
